// File: rtl/ravenoc_pkg.sv
// Shared constants and types for the NoC egress arbiter.
// Flit type occupies the two most significant bits of every flit.
package ravenoc_pkg;

  localparam int FLIT_WIDTH = 32;
  localparam int N_VIRT_CHN = 2;
  localparam int VC_WIDTH   = $clog2(N_VIRT_CHN);
  localparam int TYPE_MSB   = FLIT_WIDTH - 1;
  localparam int TYPE_LSB   = FLIT_WIDTH - 2;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } s_flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic is_head(input s_flit_type_t t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

  function automatic logic [VC_WIDTH-1:0] onehot_to_idx(input logic [N_VIRT_CHN-1:0] oh);
    logic [VC_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_VIRT_CHN; i++) begin
      if (oh[i]) begin
        idx = idx | VC_WIDTH'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_prio_arb.sv
// Combinational fixed-priority arbiter: the highest set request index wins.
module vc_prio_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Later (higher) indices overwrite earlier ones, leaving only the top request granted
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end else begin
        gnt[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/noc_egress_arb.sv
// Wormhole egress arbiter: picks a VC on a head flit, stays locked to it
// until the tail, and drives a single registered output slot.
module noc_egress_arb
  import ravenoc_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  arst,
  input  logic [N_VIRT_CHN-1:0][FLIT_WIDTH-1:0] vc_flit_i,
  input  logic [N_VIRT_CHN-1:0]                 vc_valid_i,
  output logic [N_VIRT_CHN-1:0]                 vc_ready_o,
  output logic [FLIT_WIDTH-1:0]                 flit_data_o,
  output logic                                  valid_o,
  input  logic                                  ready_i,
  output logic [VC_WIDTH-1:0]                   vc_id_o
);

  arb_state_t                  state_r, state_nxt;
  logic [VC_WIDTH-1:0]         lock_vc_r, lock_vc_nxt;
  logic [N_VIRT_CHN-1:0]       req_s, arb_gnt_s, grant_s;
  logic                        slot_free_s;
  logic [VC_WIDTH-1:0]         win_idx_s;
  logic [FLIT_WIDTH-1:0]       win_flit_s;
  s_flit_type_t                win_type_s;

  // Eligible requests depend on whether a packet currently owns the output
  always_comb begin
    req_s = '0;
    case (state_r)
      IDLE: begin
        for (int i = 0; i < N_VIRT_CHN; i++) begin
          req_s[i] = vc_valid_i[i] &
                     is_head(s_flit_type_t'(vc_flit_i[i][TYPE_MSB:TYPE_LSB]));
        end
      end
      LOCKED:  req_s[lock_vc_r] = vc_valid_i[lock_vc_r];
      default: req_s = '0;
    endcase
  end

  vc_prio_arb #(.N(N_VIRT_CHN)) u_prio_arb (
    .req (req_s),
    .gnt (arb_gnt_s)
  );

  // Ready is gated by reset so nothing is accepted while arst is held low
  assign slot_free_s = !valid_o || ready_i;
  assign grant_s     = (slot_free_s && arst) ? arb_gnt_s : '0;
  assign vc_ready_o  = grant_s;
  assign win_idx_s   = onehot_to_idx(grant_s);
  assign win_flit_s  = vc_flit_i[win_idx_s];
  assign win_type_s  = s_flit_type_t'(win_flit_s[TYPE_MSB:TYPE_LSB]);

  // Next-state: lock on HEAD, release only on TAIL (HEAD/HEAD_TAIL while locked act as BODY)
  always_comb begin
    state_nxt   = state_r;
    lock_vc_nxt = lock_vc_r;
    case (state_r)
      IDLE: begin
        if ((|grant_s) && (win_type_s == HEAD)) begin
          state_nxt   = LOCKED;
          lock_vc_nxt = win_idx_s;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOCKED: begin
        if ((|grant_s) && (win_type_s == TAIL)) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = LOCKED;
        end
      end
      default: begin
        state_nxt   = IDLE;
        lock_vc_nxt = '0;
      end
    endcase
  end

  // State and lock registers
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_r   <= IDLE;
      lock_vc_r <= '0;
    end else begin
      state_r   <= state_nxt;
      lock_vc_r <= lock_vc_nxt;
    end
  end

  // Output slot: load on grant, empty after an egress transfer with no refill
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      valid_o     <= 1'b0;
      flit_data_o <= '0;
      vc_id_o     <= '0;
    end else if (|grant_s) begin
      valid_o     <= 1'b1;
      flit_data_o <= win_flit_s;
      vc_id_o     <= win_idx_s;
    end else if (ready_i) begin
      valid_o     <= 1'b0;
    end
  end

endmodule
